// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, flash req/ack, decoder buffer
//
// Optional feature macro: PREFETCH_BUF_EN (two-entry instruction buffer
// instead of one, so fetch runs one word ahead while the decoder stalls).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_req, mem_addr        flash read request and address (held until ack)
//   mem_ack, mem_rdata       flash read completion and data (same cycle)
//   instr, instr_addr        buffered instruction word and its flash address
//   instr_valid, instr_ready decoder handshake
//   jump_en, jump_addr       single-cycle redirect from the decoder
//   halt                     level; stops issue of new flash requests
module instr_fetch #(
  parameter int ADDR_W = 9,
  parameter int INSTR_W = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_addr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt
);

`ifdef PREFETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  // Request tracker: BUSY is a plain outstanding read, DROP is an outstanding
  // read whose data must be thrown away because a jump overtook it.
  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_BUSY,
    REQ_DROP
  } req_state_t;

  req_state_t        state;
  req_state_t        state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        count;
  logic [1:0]        count_after_pop;
  logic              outstanding;
  logic              discard;
  logic              pop;
  logic              push;
  logic              room;

  assign outstanding     = (state != REQ_IDLE);
  assign discard         = (state == REQ_DROP);
  assign instr_valid     = (count != 2'd0);
  assign pop             = instr_valid & instr_ready;
  assign push            = mem_ack & ~discard & ~jump_en;
  // A pop in the same cycle frees its slot, which keeps 1 word/cycle with
  // a single-entry buffer.
  assign count_after_pop = count - {1'b0, pop};
  assign room            = (count_after_pop < 2'(DEPTH));
  // The pc moves on a jump even while a read is in flight, so the in-flight
  // address is held separately to keep mem_addr stable until the ack.
  assign mem_addr        = outstanding ? req_addr : pc;

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    if (!rst) begin
      mem_req = outstanding | (~halt & ~jump_en & room);
    end
    case (state)
      REQ_IDLE: begin
        if (mem_req && !mem_ack) state_next = REQ_BUSY;
      end
      REQ_BUSY: begin
        if (mem_ack)      state_next = REQ_IDLE;
        else if (jump_en) state_next = REQ_DROP;
      end
      REQ_DROP: begin
        if (mem_ack) state_next = REQ_IDLE;
      end
      default: state_next = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= REQ_IDLE;
      pc       <= RESET_PC;
      req_addr <= '0;
    end else begin
      state <= state_next;
      if (state == REQ_IDLE && mem_req && !mem_ack) begin
        req_addr <= pc;
      end
      if (jump_en) begin
        pc <= jump_addr;
      end else if (mem_ack && !discard) begin
        pc <= pc + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
    end else if (jump_en) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef PREFETCH_BUF_EN
  // Two entries as a shift pair: head drives the outputs, tail waits behind.
  logic [INSTR_W-1:0] tail_instr;
  logic [ADDR_W-1:0]  tail_addr;
  logic               head_from_tail;
  logic               head_from_mem;
  logic               tail_from_mem;

  assign head_from_tail = pop & (count == 2'd2);
  assign head_from_mem  = push & ((count == 2'd0) | ((count == 2'd1) & pop));
  assign tail_from_mem  = push & (((count == 2'd1) & ~pop) | ((count == 2'd2) & pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr      <= '0;
      instr_addr <= '0;
      tail_instr <= '0;
      tail_addr  <= '0;
    end else begin
      if (head_from_tail) begin
        instr      <= tail_instr;
        instr_addr <= tail_addr;
      end else if (head_from_mem) begin
        instr      <= mem_rdata;
        instr_addr <= mem_addr;
      end
      if (tail_from_mem) begin
        tail_instr <= mem_rdata;
        tail_addr  <= mem_addr;
      end
    end
  end
`else
  // Single entry: a push only happens when the entry is empty or being
  // popped in the same cycle, so it always overwrites the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr      <= '0;
      instr_addr <= '0;
    end else if (push) begin
      instr      <= mem_rdata;
      instr_addr <= mem_addr;
    end
  end
`endif

endmodule
